mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-copy initiator for the word-addressed data memory port. On a start request it moves `word_count` consecutive 32-bit words from `src_addr` to `dst_addr`. It drives `MemRead`/`MemWrite`/`address`/`WriteData` and captures `ReadData`. It sits beside the core as a second master on the data-memory bus; bus arbitration is external.

## Interface
- `CNT_W`, default 16: width of the word count and progress counter.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: copy request, sampled only in IDLE.
- `src_addr` input, 32: byte address of the first source word; bits [1:0] are ignored.
- `dst_addr` input, 32: byte address of the first destination word; bits [1:0] are ignored.
- `word_count` input, CNT_W: number of words to copy.
- `busy` output, 1: high while a copy is in progress.
- `done` output, 1: one-cycle completion pulse.
- `words_done` output, CNT_W: number of words written so far in the current copy.
- `MemRead` output, 1: memory read strobe.
- `MemWrite` output, 1: memory write strobe; the memory commits the write on the rising edge of `clk`.
- `address` output, 32: memory byte address, always issued with bits [1:0] = 00.
- `WriteData` output, 32: write data.
- `ReadData` input, 32: combinational read data from the memory, valid in the same cycle as `MemRead`.
- `checksum` output, 32: present only with `MEM_COPY_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, READ, WRITE, DONE (Moore).
- **IDLE**
  - `start` = 1 and `word_count` != 0: latch `src_addr`, `dst_addr` and `word_count` (all with bits [1:0] cleared where applicable), clear `words_done`, go to READ.
  - `start` = 1 and `word_count` = 0: go to DONE. No bus activity occurs.
- **READ**
  - `MemRead` = 1, `address` = source pointer.
  - At the end of the cycle, capture `ReadData` into the data buffer.
  - Go to WRITE.
- **WRITE**
  - `MemWrite` = 1, `address` = destination pointer, `WriteData` = data buffer.
  - At the end of the cycle: increment both pointers by 4, increment `words_done`.
  - If `words_done` + 1 = latched count, go to DONE; otherwise go to READ.
- **DONE**
  - `done` = 1 for this single cycle, then go to IDLE.
- `busy` = 1 in READ and WRITE only.
- `start` is ignored outside IDLE. Inputs may change freely after they are latched.
- `MemRead` and `MemWrite` are never high in the same cycle.
- Outside READ and WRITE: `address` = 0, `WriteData` = 0, both strobes low.
- Pointer arithmetic is modulo 2^32. Incrementing past 0xFFFFFFFC wraps to 0x00000000.
- Copies always run in ascending address order, with no overlap correction.
  - If `dst_addr` > `src_addr` and the regions overlap, already-written words are re-read, so the first `dst_addr` − `src_addr` bytes repeat as a pattern. This is the specified behaviour.
- Reset mid-copy: the FSM returns to IDLE immediately and all outputs take their reset values. Words already written stay in memory.

## Timing
- Reset values: `busy`, `done`, `MemRead`, `MemWrite` = 0; `address`, `WriteData`, `words_done`, `checksum` = 0; state = IDLE.
- Let edge 0 be the edge at which `start` is accepted:
  - READ of word k occupies cycle 2k+1.
  - WRITE of word k occupies cycle 2k+2.
  - `done` is high in cycle 2N+1 (N = word count).
- Zero-length copy: `done` is high in cycle 1.
- Throughput: one word per 2 cycles.
- Back-to-back copies: `start` is accepted in the cycle after `done`, at the earliest.

## Configuration
- `MEM_COPY_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - Cleared when `start` is accepted.
  - Each word is added modulo 2^32 when it is captured from `ReadData`.
  - Holds its value after `done` until the next accepted start or reset.
- Not defined: no `checksum` port and no adder logic. All other behaviour is identical.

## Structure
- Package `mem_copy_pkg`:
  - State enum `mem_copy_state_t` (IDLE, READ, WRITE, DONE).
  - `WORD_BYTES` = 4.
  - `ADDR_W` = 32.
- Sub-module `mem_copy_addr_gen`: source/destination pointer registers, +4 increment, word-alignment masking. Controlled by load/advance strobes from the FSM.

## Test plan
- **Single word:** mem[0x40] = 0xDEADBEEF; start with src 0x40, dst 0x80, count 1 → READ at cycle 1, WRITE at cycle 2 with `WriteData` = 0xDEADBEEF, `done` at cycle 3, mem[0x80] = 0xDEADBEEF.
- **Eight words:** src 0x100, dst 0x200, count 8, source holds 1..8 → dst 0x200–0x21C hold 1..8, `done` at cycle 17, `words_done` = 8, checksum = 36 (with `MEM_COPY_CHECKSUM_EN`).
- **Zero count and ignored start:** count 0 → `done` at cycle 1 with no strobes. `start` pulsed while `busy` → no restart and no change to the copy.
- **Misaligned and overlapping:** src 0x103, dst 0x006 → `address` shows 0x100 and 0x004. Src 0x0, dst 0x4, count 4, mem[0] = 0xA → words 0x4–0x10 all read 0xA.
- **Wrap and reset:** src 0xFFFFFFFC, count 2 → second read at address 0x00000000. Assert `rst_n` low during a WRITE cycle of a 4-word copy → outputs zero immediately, state IDLE, only words completed before reset are present.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state type and address constants for the block-copy engine
package mem_copy_pkg;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mem_copy_state_t;
endpackage

// File: rtl/mem_copy_addr_gen.sv
// mem_copy_addr_gen: word-aligned source/destination pointers with load and advance strobes
module mem_copy_addr_gen
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
  logic [ADDR_W-1:0] src_d, src_q, dst_d, dst_q;
  always_comb begin
    src_d = load ? (src_in & ALIGN_MASK) : advance ? src_q + STEP : src_q;
    dst_d = load ? (dst_in & ALIGN_MASK) : advance ? dst_q + STEP : dst_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
    end
  assign src_ptr = src_q;
  assign dst_ptr = dst_q;
endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: ascending word-by-word memory copy master; MEM_COPY_CHECKSUM_EN adds a running read checksum
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_done,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       WriteData,
  input  logic [31:0]       ReadData
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);
  mem_copy_state_t state_q, state_d;
  logic [CNT_W-1:0] words_done_q, words_done_d, count_q, count_d;
  logic [31:0] data_q, data_d;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic accept, load, last;
  assign accept = (state_q == IDLE) && start;
  assign load = accept && (word_count != '0);
  assign last = (words_done_q + CNT_W'(1)) == count_q;
  mem_copy_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (state_q == WRITE),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start ? IDLE : (word_count != '0) ? READ : DONE;
      READ:    state_d = WRITE;
      WRITE:   state_d = last ? DONE : READ;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy      = (state_q == READ) || (state_q == WRITE);
    done      = state_q == DONE;
    MemRead   = state_q == READ;
    MemWrite  = state_q == WRITE;
    address   = (state_q == READ) ? src_ptr : (state_q == WRITE) ? dst_ptr : '0;
    WriteData = (state_q == WRITE) ? data_q : '0;
  end
  always_comb begin
    words_done_d = load ? '0 : (state_q == WRITE) ? words_done_q + CNT_W'(1) : words_done_q;
    count_d      = load ? word_count : count_q;
    data_d       = (state_q == READ) ? ReadData : data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      words_done_q <= '0;
      count_q      <= '0;
      data_q       <= '0;
    end else begin
      words_done_q <= words_done_d;
      count_q      <= count_d;
      data_q       <= data_d;
    end
  assign words_done = words_done_q;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
  always_comb checksum_d = accept ? '0 : (state_q == READ) ? checksum_q + ReadData : checksum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) checksum_q <= '0;
    else checksum_q <= checksum_d;
  assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: per-cycle check of the copy engine against a word-level copy model
module tb_mem_copy_engine;
  localparam int CNT_W = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0, ReadData;
  logic [CNT_W-1:0] word_count = '0, words_done;
  logic busy, done, MemRead, MemWrite;
  logic [31:0] address, WriteData;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int checks = 0, errors = 0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int mem_ver = 0;
  typedef struct {
    logic busy, done, rd, wr;
    logic [31:0] addr, wdata, cs;
    logic [CNT_W-1:0] wd;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  logic [CNT_W-1:0] idle_wd = '0;
  logic [31:0] idle_cs = '0;
  logic [31:0] rd_log[$], wr_log[$];

  always #5 clk = ~clk;

  mem_copy_engine #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // 4 KB memory image; addresses alias modulo 4 KB identically in DUT memory and model
  always @(posedge clk)
    if (MemWrite) begin
      mem[address[11:2]] <= WriteData;
      mem_ver <= mem_ver + 1;
    end
  always @(MemRead or address or mem_ver) ReadData = MemRead ? mem[address[11:2]] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[11:2]] <= v;
    ref_mem[a[11:2]] = v;
  endtask

  // Word-level model: copy in ascending order, reading the model memory after earlier writes
  task automatic build(input logic [31:0] s_in, input logic [31:0] d_in, input logic [CNT_W-1:0] n);
    logic [31:0] s, d, cs, data;
    s = s_in & ~32'h3;
    d = d_in & ~32'h3;
    cs = 32'h0;
    for (int k = 0; k < int'(n); k++) begin
      data = ref_mem[s[11:2]];
      q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, s, 32'h0, cs, CNT_W'(k)});
      cs = cs + data;
      q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, d, data, cs, CNT_W'(k)});
      ref_mem[d[11:2]] = data;
      s = s + 32'd4;
      d = d + 32'd4;
    end
    if (n != '0) idle_wd = n;
    idle_cs = cs;
    q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, cs, idle_wd});
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, idle_cs, idle_wd};
      check("busy", 32'(busy), 32'(cur.busy));
      check("done", 32'(done), 32'(cur.done));
      check("MemRead", 32'(MemRead), 32'(cur.rd));
      check("MemWrite", 32'(MemWrite), 32'(cur.wr));
      check("address", address, cur.addr);
      check("WriteData", WriteData, cur.wdata);
      check("words_done", 32'(words_done), 32'(cur.wd));
`ifdef MEM_COPY_CHECKSUM_EN
      check("checksum", checksum, cur.cs);
`endif
    end

  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [CNT_W-1:0] n,
                     input bit poke_start, output int dc);
    @(posedge clk);
    #2;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    word_count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    word_count = CNT_W'($urandom);
    build(s, d, n);
    rd_log.delete();
    wr_log.delete();
    dc = -1;
    for (int c = 1; c <= 2 * int'(n) + 10; c++) begin
      @(negedge clk);
      #1;
      if (MemRead) rd_log.push_back(address);
      if (MemWrite) wr_log.push_back(address);
      if (done) begin
        dc = c;
        break;
      end
      start = poke_start && busy && ($urandom_range(2) == 0);
    end
    start = 1'b0;
    check("done_cycle", dc, 2 * int'(n) + 1);
  endtask

  initial begin
    int dc;
    bit found;
    logic [31:0] saved [4];
    logic [31:0] s, d;
    for (int i = 0; i < 1024; i++) poke(32'(i) << 2, $urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_strobes", 32'({MemRead, MemWrite}), 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_words_done", 32'(words_done), 32'h0);
`ifdef MEM_COPY_CHECKSUM_EN
    check("rst_checksum", checksum, 32'h0);
`endif
    #1 rst_n = 1'b1;

    poke(32'h40, 32'hDEADBEEF);
    run(32'h40, 32'h80, 1, 1'b0, dc);
    check("single_cycle", dc, 3);
    check("single_rd_cnt", rd_log.size(), 1);
    if (rd_log.size() > 0) check("single_rd_addr", rd_log[0], 32'h40);
    if (wr_log.size() > 0) check("single_wr_addr", wr_log[0], 32'h80);
    check("single_mem", mem[32'h80 >> 2], 32'hDEADBEEF);

    for (int k = 0; k < 8; k++) poke(32'h100 + 32'(4 * k), 32'(k + 1));
    run(32'h100, 32'h200, 8, 1'b1, dc);
    check("eight_cycle", dc, 17);
    check("eight_words_done", 32'(words_done), 32'd8);
`ifdef MEM_COPY_CHECKSUM_EN
    check("eight_checksum", checksum, 32'd36);
`endif
    for (int k = 0; k < 8; k++) check("eight_mem", mem[(32'h200 >> 2) + k], 32'(k + 1));

    run(32'h500, 32'h600, 0, 1'b0, dc);
    check("zero_cycle", dc, 1);
    check("zero_strobes", rd_log.size() + wr_log.size(), 0);

    run(32'h103, 32'h006, 2, 1'b0, dc);
    if (rd_log.size() > 0) check("misalign_rd", rd_log[0], 32'h100);
    if (wr_log.size() > 0) check("misalign_wr", wr_log[0], 32'h004);

    poke(32'h0, 32'hA);
    run(32'h0, 32'h4, 4, 1'b0, dc);
    for (int k = 1; k <= 4; k++) check("overlap_mem", mem[k], 32'hA);

    run(32'hFFFFFFFC, 32'h800, 2, 1'b0, dc);
    check("wrap_rd_cnt", rd_log.size(), 2);
    if (rd_log.size() > 1) check("wrap_rd_addr", rd_log[1], 32'h0);

    for (int k = 0; k < 4; k++) begin
      poke(32'h300 + 32'(4 * k), $urandom);
      saved[k] = ref_mem[(32'h380 >> 2) + k];
    end
    @(posedge clk);
    #2;
    start = 1'b1;
    src_addr = 32'h300;
    dst_addr = 32'h380;
    word_count = 4;
    @(posedge clk);
    #1;
    start = 1'b0;
    build(32'h300, 32'h380, 4);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (MemWrite && words_done == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_reached", 32'(found), 32'h1);
    rst_n = 1'b0;
    q.delete();
    idle_wd = '0;
    idle_cs = '0;
    for (int k = 1; k < 4; k++) ref_mem[(32'h380 >> 2) + k] = saved[k];
    #1;
    check("async_busy", 32'(busy), 32'h0);
    check("async_strobes", 32'({MemRead, MemWrite}), 32'h0);
    check("async_address", address, 32'h0);
    check("async_wdata", WriteData, 32'h0);
    check("async_words_done", 32'(words_done), 32'h0);
    check("reset_word0", mem[32'h380 >> 2], mem[32'h300 >> 2]);
    check("reset_word1", mem[(32'h380 >> 2) + 1], saved[1]);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      s = $urandom;
      d = $urandom;
      run(s, d, CNT_W'($urandom_range(0, 12)), 1'b1, dc);
    end
    @(negedge clk);
    for (int i = 0; i < 1024; i++) check("final_mem", mem[i], ref_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
